rv32_mem_arbiter: RTL and testbench
===================================

// Module: rv32_mem_arbiter
// PURPOSE
//  Shares one single-port synchronous RAM between the core's instruction-fetch port and
//  the LSU data port. Accepts one access at a time and drives the RAM. Returns read data
//  and a one-cycle ready pulse to the owning requester.
//  Data has fixed priority; a starvation counter guarantees forward progress of fetch.
//  Sits between rv32_core (imem_*/dmem_ram_*) and the shared RAM macro.
// PARAMETERS
//  AW           32  address width (byte address)
//  DW           32  data width
//  LAT          1   RAM read latency in cycles after the ram_req cycle (legal 1..7)
//  MAX_D_BURST  4   consecutive data grants allowed while i_req waits (legal 1..15)
// PORTS
//  clk        in   1     clock, all state updates on rising edge
//  rstn       in   1     reset, synchronous, active-low
//  i_req      in   1     fetch request, held until i_ready
//  i_addr     in   AW    fetch address
//  i_rdata    out  DW    fetch data, valid only when i_ready=1
//  i_ready    out  1     fetch access complete (1-cycle pulse)
//  d_req      in   1     data request, held until d_ready
//  d_we       in   1     1=write, 0=read
//  d_be       in   DW/8  byte enables (writes)
//  d_addr     in   AW    data address
//  d_wdata    in   DW    write data
//  d_rdata    out  DW    read data, valid only when d_ready=1
//  d_ready    out  1     data access complete (1-cycle pulse)
//  ram_req    out  1     RAM access strobe (1 cycle per access)
//  ram_we     out  1     RAM write enable
//  ram_be     out  DW/8  RAM byte enables
//  ram_addr   out  AW    RAM address
//  ram_wdata  out  DW    RAM write data
//  ram_rdata  in   DW    RAM read data, valid LAT cycles after ram_req
//  busy       out  1     1 while state != IDLE
// BEHAVIOUR
//  - FSM: IDLE -> ISSUE -> WAIT -> IDLE.
//    IDLE: arbitrate if any req, else stay.
//    ISSUE: ram_req=1 for exactly this cycle. Load cnt=LAT.
//    WAIT: decrement cnt. On cnt==1, the owner's ready=1 and the FSM returns to IDLE.
//  - Latency: request seen in IDLE at cycle t -> ram_req at t+1 -> ready at t+1+LAT.
//    One access per LAT+2 cycles maximum.
//  - ram_we/ram_be/ram_addr/ram_wdata: registered, latched at grant, held until next grant.
//    For a fetch grant: ram_we=0, ram_be=all ones, ram_wdata=0.
//  - Writes complete with the same timing as reads. d_rdata is don't-care for writes.
//  - i_rdata and d_rdata are both driven from ram_rdata. Consumers qualify with ready.
//  - Grant rule in IDLE:
//    - only one req: grant it.
//    - both req, streak<MAX_D_BURST: grant data.
//    - both req, streak==MAX_D_BURST: grant fetch.
//  - streak (4 bit): +1 on a data grant while i_req=1; cleared on a fetch grant.
//    Cleared on a data grant while i_req=0. Saturates at MAX_D_BURST.
//  - Request inputs are sampled only in IDLE.
//    Changes after grant do not affect the in-flight access.
//    A req dropped before grant is ignored; no error is raised.
//  - A req still high in the cycle after its ready is a new request.
//    It is arbitrated normally.
//  - Owner register (1 bit) selects which ready pulses. i_ready and d_ready are never both 1.
//  - Reset (rstn=0 at a clock edge, any state): state=IDLE, ram_req=0, ram_we=0, ram_be=0,
//    ram_addr=0, ram_wdata=0, i_ready=0, d_ready=0, busy=0, streak=0, cnt=0.
//    An in-flight access is aborted; no ready is produced for it.
//    RAM data arriving afterwards is discarded.
// TESTING
//  1 Single fetch, LAT=1: i_req=1, i_addr=0x100, RAM[0x100]=0x00A00093 at t0 ->
//    ram_req=1 at t1 with ram_addr=0x100, ram_we=0;
//    i_ready=1 with i_rdata=0x00A00093 at t2; busy=0 at t3.
//  2 Data write: d_req=1, d_we=1, d_be=4'b0011, d_addr=0x200, d_wdata=0xDEADBEEF ->
//    ram_we=1, ram_be=0011 at t1; d_ready at t1+LAT; RAM[0x200] low half=0xBEEF.
//  3 Simultaneous requests, MAX_D_BURST=4:
//    i_req and d_req held high, d_req re-asserted after each d_ready ->
//    4 data grants, then 1 fetch grant, then data again; i_ready never overlaps d_ready.
//  4 LAT=3 read: d_req at t0 -> ram_req at t1, d_ready at t4;
//    changing d_addr at t2 leaves ram_addr unchanged.
//  5 Reset mid-op: rstn=0 in WAIT with cnt=2 ->
//    next cycle all outputs at reset values; no d_ready/i_ready pulse for the aborted access.
//  6 Withdrawn request: i_req high 1 cycle while FSM in WAIT, low before IDLE ->
//    no fetch grant, no ram_req, streak unchanged.

Source files
------------

// File: rtl/rv32_mem_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and the LSU data port.
// Data wins ties, but a streak counter hands the RAM to fetch after MAX_D_BURST data grants.
module rv32_mem_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int LAT         = 1,
    parameter int MAX_D_BURST = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic [DW-1:0]   i_rdata,
    output logic            i_ready,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [DW/8-1:0] d_be,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic [DW-1:0]   d_rdata,
    output logic            d_ready,
    output logic            ram_req,
    output logic            ram_we,
    output logic [DW/8-1:0] ram_be,
    output logic [AW-1:0]   ram_addr,
    output logic [DW-1:0]   ram_wdata,
    input  logic [DW-1:0]   ram_rdata,
    output logic            busy
);
    localparam logic [2:0] LAT_C = 3'(LAT);
    localparam logic [3:0] MAX_C = 4'(MAX_D_BURST);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t          r_state, w_state_nxt;
    logic [2:0]      r_cnt, w_cnt_nxt;
    logic [3:0]      r_streak, w_streak_nxt;
    logic            r_owner_d, w_owner_nxt;
    logic            w_grant, w_grant_d, w_done;
    logic            r_ram_we;
    logic [DW/8-1:0] r_ram_be;
    logic [AW-1:0]   r_ram_addr;
    logic [DW-1:0]   r_ram_wdata;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_streak_nxt = r_streak;
        w_owner_nxt  = r_owner_d;
        w_grant      = 1'b0;
        w_grant_d    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_req || d_req) begin
                    w_grant     = 1'b1;
                    w_grant_d   = d_req && (!i_req || (r_streak < MAX_C));
                    w_owner_nxt = w_grant_d;
                    w_state_nxt = S_ISSUE;
                    // Streak only grows while fetch is actually being held off.
                    if (w_grant_d && i_req)
                        w_streak_nxt = (r_streak < MAX_C) ? r_streak + 4'd1 : r_streak;
                    else
                        w_streak_nxt = 4'd0;
                end
            end
            S_ISSUE: begin
                w_cnt_nxt   = LAT_C;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - 3'd1;
                if (r_cnt == 3'd1) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_cnt       <= 3'd0;
            r_streak    <= 4'd0;
            r_owner_d   <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_be    <= '0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_streak  <= w_streak_nxt;
            r_owner_d <= w_owner_nxt;
            // RAM command is captured at grant so requesters may change inputs afterwards.
            if (w_grant) begin
                if (w_grant_d) begin
                    r_ram_we    <= d_we;
                    r_ram_be    <= d_be;
                    r_ram_addr  <= d_addr;
                    r_ram_wdata <= d_wdata;
                end else begin
                    r_ram_we    <= 1'b0;
                    r_ram_be    <= '1;
                    r_ram_addr  <= i_addr;
                    r_ram_wdata <= '0;
                end
            end
        end
    end

    assign w_done    = (r_state == S_WAIT) && (r_cnt == 3'd1);
    assign i_ready   = w_done && !r_owner_d;
    assign d_ready   = w_done && r_owner_d;
    assign i_rdata   = ram_rdata;
    assign d_rdata   = ram_rdata;
    assign ram_req   = (r_state == S_ISSUE);
    assign busy      = (r_state != S_IDLE);
    assign ram_we    = r_ram_we;
    assign ram_be    = r_ram_be;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Bench for rv32_mem_arbiter: directed scenarios on LAT=1 and LAT=3 instances plus a
// randomized run against a cycle-level transaction model with a shadow memory.
module tb_rv32_mem_arbiter;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;
    localparam int MAXB  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic        a_rstn, a_i_req, a_i_ready, a_d_req, a_d_we, a_d_ready, a_ram_req, a_ram_we, a_busy;
    logic [31:0] a_i_addr, a_i_rdata, a_d_addr, a_d_wdata, a_d_rdata, a_ram_addr, a_ram_wdata, a_ram_rdata;
    logic [3:0]  a_d_be, a_ram_be;
    logic        b_rstn, b_i_req, b_i_ready, b_d_req, b_d_we, b_d_ready, b_ram_req, b_ram_we, b_busy;
    logic [31:0] b_i_addr, b_i_rdata, b_d_addr, b_d_wdata, b_d_rdata, b_ram_addr, b_ram_wdata, b_ram_rdata;
    logic [3:0]  b_d_be, b_ram_be;

    rv32_mem_arbiter #(.LAT(LAT_A), .MAX_D_BURST(MAXB)) u_dut_a (
        .clk(clk), .rstn(a_rstn), .i_req(a_i_req), .i_addr(a_i_addr), .i_rdata(a_i_rdata),
        .i_ready(a_i_ready), .d_req(a_d_req), .d_we(a_d_we), .d_be(a_d_be), .d_addr(a_d_addr),
        .d_wdata(a_d_wdata), .d_rdata(a_d_rdata), .d_ready(a_d_ready), .ram_req(a_ram_req),
        .ram_we(a_ram_we), .ram_be(a_ram_be), .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata),
        .ram_rdata(a_ram_rdata), .busy(a_busy));

    rv32_mem_arbiter #(.LAT(LAT_B), .MAX_D_BURST(MAXB)) u_dut_b (
        .clk(clk), .rstn(b_rstn), .i_req(b_i_req), .i_addr(b_i_addr), .i_rdata(b_i_rdata),
        .i_ready(b_i_ready), .d_req(b_d_req), .d_we(b_d_we), .d_be(b_d_be), .d_addr(b_d_addr),
        .d_wdata(b_d_wdata), .d_rdata(b_d_rdata), .d_ready(b_d_ready), .ram_req(b_ram_req),
        .ram_we(b_ram_we), .ram_be(b_ram_be), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata),
        .ram_rdata(b_ram_rdata), .busy(b_busy));

    // Behavioural RAMs: data is only meaningful exactly LAT cycles after a read strobe.
    logic [31:0] mem_a [256];
    logic [31:0] rd_a  [LAT_A];
    logic        a_init, a_pl_we;
    logic [7:0]  a_pl_idx;
    logic [31:0] a_pl_data;
    always @(posedge clk) begin
        if (a_init) for (int k = 0; k < 256; k++) mem_a[k] <= 32'(k) * 32'h9E3779B1 + 32'h1234;
        if (a_pl_we) mem_a[a_pl_idx] <= a_pl_data;
        if (a_ram_req && a_ram_we)
            for (int k = 0; k < 4; k++)
                if (a_ram_be[k]) mem_a[a_ram_addr[9:2]][8*k +: 8] <= a_ram_wdata[8*k +: 8];
        rd_a[0] <= (a_ram_req && !a_ram_we) ? mem_a[a_ram_addr[9:2]] : 32'hDEADDEAD;
        for (int k = 1; k < LAT_A; k++) rd_a[k] <= rd_a[k-1];
    end
    assign a_ram_rdata = rd_a[LAT_A-1];

    logic [31:0] mem_b [256];
    logic [31:0] rd_b  [LAT_B];
    logic        b_pl_we;
    logic [7:0]  b_pl_idx;
    logic [31:0] b_pl_data;
    always @(posedge clk) begin
        if (b_pl_we) mem_b[b_pl_idx] <= b_pl_data;
        if (b_ram_req && b_ram_we)
            for (int k = 0; k < 4; k++)
                if (b_ram_be[k]) mem_b[b_ram_addr[9:2]][8*k +: 8] <= b_ram_wdata[8*k +: 8];
        rd_b[0] <= (b_ram_req && !b_ram_we) ? mem_b[b_ram_addr[9:2]] : 32'hDEADDEAD;
        for (int k = 1; k < LAT_B; k++) rd_b[k] <= rd_b[k-1];
    end
    assign b_ram_rdata = rd_b[LAT_B-1];

    task automatic poke_a(input logic [7:0] idx, input logic [31:0] data);
        a_pl_we = 1'b1; a_pl_idx = idx; a_pl_data = data;
        @(negedge clk);
        a_pl_we = 1'b0;
    endtask

    task automatic poke_b(input logic [7:0] idx, input logic [31:0] data);
        b_pl_we = 1'b1; b_pl_idx = idx; b_pl_data = data;
        @(negedge clk);
        b_pl_we = 1'b0;
    endtask

    task automatic test_reset();
        a_rstn = 1'b0; b_rstn = 1'b0; a_init = 1'b1;
        repeat (2) @(negedge clk);
        a_init = 1'b0;
        checks++;
        if ({a_ram_req, a_ram_we, a_ram_be, a_ram_addr, a_ram_wdata, a_i_ready, a_d_ready, a_busy} !== '0) begin
            errors++; $display("FAIL reset_a outputs got=%h exp=0",
                {a_ram_req, a_ram_we, a_ram_be, a_ram_addr, a_ram_wdata, a_i_ready, a_d_ready, a_busy});
        end
        checks++;
        if ({b_ram_req, b_ram_we, b_ram_be, b_ram_addr, b_ram_wdata, b_i_ready, b_d_ready, b_busy} !== '0) begin
            errors++; $display("FAIL reset_b outputs got=%h exp=0",
                {b_ram_req, b_ram_we, b_ram_be, b_ram_addr, b_ram_wdata, b_i_ready, b_d_ready, b_busy});
        end
        a_rstn = 1'b1; b_rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (a_busy !== 1'b0 || a_ram_req !== 1'b0) begin
            errors++; $display("FAIL reset_idle busy=%b ram_req=%b exp=0/0", a_busy, a_ram_req);
        end
    endtask

    task automatic test_single_fetch();
        poke_a(8'h40, 32'h00A00093);
        a_i_req = 1'b1; a_i_addr = 32'h100;
        @(negedge clk);
        checks++;
        if ({a_ram_req, a_ram_we, a_ram_be, a_ram_addr, a_ram_wdata} !== {1'b1, 1'b0, 4'hF, 32'h100, 32'h0}) begin
            errors++; $display("FAIL fetch_issue got req=%b we=%b be=%h addr=%h wd=%h exp 1/0/f/100/0",
                a_ram_req, a_ram_we, a_ram_be, a_ram_addr, a_ram_wdata);
        end
        checks++;
        if (a_i_ready !== 1'b0) begin errors++; $display("FAIL fetch_early_ready got=%b exp=0", a_i_ready); end
        @(negedge clk);
        checks++;
        if (a_i_ready !== 1'b1 || a_d_ready !== 1'b0 || a_i_rdata !== 32'h00A00093) begin
            errors++; $display("FAIL fetch_ready i_ready=%b d_ready=%b rdata=%h exp 1/0/00a00093",
                a_i_ready, a_d_ready, a_i_rdata);
        end
        a_i_req = 1'b0;
        @(negedge clk);
        checks++;
        if (a_busy !== 1'b0 || a_i_ready !== 1'b0) begin
            errors++; $display("FAIL fetch_done busy=%b i_ready=%b exp 0/0", a_busy, a_i_ready);
        end
    endtask

    task automatic test_data_write();
        poke_a(8'h80, 32'h12345678);
        a_d_req = 1'b1; a_d_we = 1'b1; a_d_be = 4'b0011; a_d_addr = 32'h200; a_d_wdata = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if ({a_ram_req, a_ram_we, a_ram_be, a_ram_addr, a_ram_wdata} !== {1'b1, 1'b1, 4'b0011, 32'h200, 32'hDEADBEEF}) begin
            errors++; $display("FAIL write_issue got req=%b we=%b be=%h addr=%h wd=%h exp 1/1/3/200/deadbeef",
                a_ram_req, a_ram_we, a_ram_be, a_ram_addr, a_ram_wdata);
        end
        @(negedge clk);
        checks++;
        if (a_d_ready !== 1'b1 || a_i_ready !== 1'b0) begin
            errors++; $display("FAIL write_ready d_ready=%b i_ready=%b exp 1/0", a_d_ready, a_i_ready);
        end
        a_d_req = 1'b0; a_d_we = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_a[8'h80] !== 32'h1234BEEF) begin
            errors++; $display("FAIL write_mem got=%h exp=1234beef", mem_a[8'h80]);
        end
    endtask

    task automatic test_withdrawn();
        a_d_req = 1'b1; a_d_we = 1'b0; a_d_be = 4'hF; a_d_addr = 32'h010; a_i_req = 1'b0;
        @(negedge clk);
        checks++;
        if (a_ram_req !== 1'b1) begin errors++; $display("FAIL wd_issue got=%b exp=1", a_ram_req); end
        @(negedge clk);
        checks++;
        if (a_d_ready !== 1'b1) begin errors++; $display("FAIL wd_ready got=%b exp=1", a_d_ready); end
        a_d_req = 1'b0; a_i_req = 1'b1; a_i_addr = 32'h020;
        @(negedge clk);
        a_i_req = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (a_ram_req !== 1'b0 || a_i_ready !== 1'b0 || a_busy !== 1'b0) begin
                errors++; $display("FAIL wd_no_grant cyc=%0d req=%b i_ready=%b busy=%b exp 0/0/0",
                    c, a_ram_req, a_i_ready, a_busy);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_burst_fairness();
        bit exp_own [7];
        bit got_own [7];
        int ng = 0;
        exp_own = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        poke_a(8'h10, 32'h11110040);
        poke_a(8'h20, 32'h22220080);
        a_i_addr = 32'h40; a_d_addr = 32'h80; a_d_we = 1'b0; a_d_be = 4'hF;
        a_i_req = 1'b1; a_d_req = 1'b1;
        for (int c = 0; c < 60 && ng < 7; c++) begin
            @(negedge clk);
            if (a_i_ready || a_d_ready) begin
                checks++;
                if (a_i_ready && a_d_ready) begin errors++; $display("FAIL burst_overlap at ready %0d", ng); end
                checks++;
                if (a_d_ready ? (a_d_rdata !== 32'h22220080) : (a_i_rdata !== 32'h11110040)) begin
                    errors++; $display("FAIL burst_rdata ready %0d d=%b got=%h", ng, a_d_ready,
                        a_d_ready ? a_d_rdata : a_i_rdata);
                end
                got_own[ng] = a_d_ready;
                ng++;
            end
        end
        a_i_req = 1'b0; a_d_req = 1'b0;
        checks++;
        if (ng != 7) begin errors++; $display("FAIL burst_timeout readies=%0d exp=7", ng); end
        for (int k = 0; k < ng; k++) begin
            checks++;
            if (got_own[k] != exp_own[k]) begin
                errors++; $display("FAIL burst_order grant %0d data=%b exp=%b", k, got_own[k], exp_own[k]);
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_lat3_read();
        poke_b(8'hC0, 32'hCAFEF00D);
        b_d_req = 1'b1; b_d_we = 1'b0; b_d_be = 4'hF; b_d_addr = 32'h300;
        @(negedge clk);
        checks++;
        if (b_ram_req !== 1'b1 || b_ram_addr !== 32'h300 || b_ram_we !== 1'b0) begin
            errors++; $display("FAIL l3_issue req=%b addr=%h we=%b exp 1/300/0", b_ram_req, b_ram_addr, b_ram_we);
        end
        @(negedge clk);
        checks++;
        if (b_ram_req !== 1'b0 || b_busy !== 1'b1) begin
            errors++; $display("FAIL l3_t2 req=%b busy=%b exp 0/1", b_ram_req, b_busy);
        end
        b_d_addr = 32'h304;
        @(negedge clk);
        checks++;
        if (b_d_ready !== 1'b0 || b_ram_addr !== 32'h300) begin
            errors++; $display("FAIL l3_t3 d_ready=%b addr=%h exp 0/300", b_d_ready, b_ram_addr);
        end
        @(negedge clk);
        checks++;
        if (b_d_ready !== 1'b1 || b_d_rdata !== 32'hCAFEF00D || b_ram_addr !== 32'h300) begin
            errors++; $display("FAIL l3_ready d_ready=%b rdata=%h addr=%h exp 1/cafef00d/300",
                b_d_ready, b_d_rdata, b_ram_addr);
        end
        b_d_req = 1'b0;
        @(negedge clk);
        checks++;
        if (b_busy !== 1'b0 || b_d_ready !== 1'b0) begin
            errors++; $display("FAIL l3_done busy=%b d_ready=%b exp 0/0", b_busy, b_d_ready);
        end
    endtask

    task automatic test_reset_midop();
        b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 32'h300;
        repeat (3) @(negedge clk);
        checks++;
        if (b_busy !== 1'b1 || b_d_ready !== 1'b0) begin
            errors++; $display("FAIL mid_wait busy=%b d_ready=%b exp 1/0", b_busy, b_d_ready);
        end
        b_rstn = 1'b0; b_d_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({b_ram_req, b_ram_we, b_ram_be, b_ram_addr, b_ram_wdata, b_i_ready, b_d_ready, b_busy} !== '0) begin
            errors++; $display("FAIL mid_reset outputs got=%h exp=0",
                {b_ram_req, b_ram_we, b_ram_be, b_ram_addr, b_ram_wdata, b_i_ready, b_d_ready, b_busy});
        end
        b_rstn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (b_d_ready !== 1'b0 || b_i_ready !== 1'b0 || b_ram_req !== 1'b0 || b_busy !== 1'b0) begin
                errors++; $display("FAIL mid_after cyc=%0d d_ready=%b i_ready=%b req=%b busy=%b exp all 0",
                    c, b_d_ready, b_i_ready, b_ram_req, b_busy);
            end
        end
    endtask

    // Transaction model: a grant happens in any cycle the RAM is free and someone asks;
    // its strobe follows one cycle later and its ready LAT cycles after that.
    task automatic test_random();
        logic [31:0] sh [256];
        int          next_free = 0, grant_c = -1, req_c = -1, rdy_c = -1, streak = 0;
        bit          ip = 0, dp = 0, own_d = 0, e_we = 0;
        logic [3:0]  e_be = '0;
        logic [31:0] e_addr = '0, e_wdata = '0;
        a_i_req = 1'b0; a_d_req = 1'b0; a_rstn = 1'b0;
        @(negedge clk);
        a_rstn = 1'b1;
        for (int k = 0; k < 256; k++) sh[k] = mem_a[k];
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            checks++;
            if (a_ram_req !== (n == req_c)) begin
                errors++; $display("FAIL rnd_ram_req cyc=%0d got=%b exp=%b", n, a_ram_req, n == req_c);
            end
            if (n == req_c) begin
                checks++;
                if ({a_ram_we, a_ram_be, a_ram_addr, a_ram_wdata} !== {e_we, e_be, e_addr, e_wdata}) begin
                    errors++; $display("FAIL rnd_cmd cyc=%0d got=%b/%h/%h/%h exp=%b/%h/%h/%h", n,
                        a_ram_we, a_ram_be, a_ram_addr, a_ram_wdata, e_we, e_be, e_addr, e_wdata);
                end
            end
            checks++;
            if (a_i_ready !== (n == rdy_c && !own_d) || a_d_ready !== (n == rdy_c && own_d)) begin
                errors++; $display("FAIL rnd_ready cyc=%0d i=%b d=%b exp i=%b d=%b", n, a_i_ready,
                    a_d_ready, n == rdy_c && !own_d, n == rdy_c && own_d);
            end
            checks++;
            if (a_busy !== (n > grant_c && n < next_free)) begin
                errors++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", n, a_busy, n > grant_c && n < next_free);
            end
            if (n == rdy_c) begin
                if (own_d && e_we) begin
                    for (int k = 0; k < 4; k++) if (e_be[k]) sh[e_addr[9:2]][8*k +: 8] = e_wdata[8*k +: 8];
                end else begin
                    checks++;
                    if ((own_d ? a_d_rdata : a_i_rdata) !== sh[e_addr[9:2]]) begin
                        errors++; $display("FAIL rnd_rdata cyc=%0d d=%b got=%h exp=%h", n, own_d,
                            own_d ? a_d_rdata : a_i_rdata, sh[e_addr[9:2]]);
                    end
                end
                if (own_d) dp = 0; else ip = 0;
            end
            if (!ip) begin
                if ($urandom_range(0, 1) == 1) begin
                    ip = 1; a_i_req = 1'b1; a_i_addr = {22'd0, 8'($urandom), 2'b00};
                end else a_i_req = 1'b0;
            end
            if (!dp) begin
                if ($urandom_range(0, 1) == 1) begin
                    dp = 1; a_d_req = 1'b1; a_d_we = 1'($urandom); a_d_be = 4'($urandom);
                    a_d_addr = {22'd0, 8'($urandom), 2'b00}; a_d_wdata = $urandom;
                end else a_d_req = 1'b0;
            end
            if (n >= next_free && (a_i_req || a_d_req)) begin
                own_d = a_d_req && (!a_i_req || streak < MAXB);
                if (own_d && a_i_req) streak = (streak < MAXB) ? streak + 1 : streak;
                else streak = 0;
                if (own_d) begin
                    e_we = a_d_we; e_be = a_d_be; e_addr = a_d_addr; e_wdata = a_d_wdata;
                end else begin
                    e_we = 1'b0; e_be = 4'hF; e_addr = a_i_addr; e_wdata = 32'h0;
                end
                grant_c = n; req_c = n + 1; rdy_c = n + 1 + LAT_A; next_free = n + LAT_A + 2;
            end
        end
        a_i_req = 1'b0; a_d_req = 1'b0;
        repeat (LAT_A + 3) @(negedge clk);
    endtask

    initial begin
        a_rstn = 1'b0; a_i_req = 1'b0; a_i_addr = '0; a_d_req = 1'b0; a_d_we = 1'b0; a_d_be = '0;
        a_d_addr = '0; a_d_wdata = '0; a_init = 1'b0; a_pl_we = 1'b0; a_pl_idx = '0; a_pl_data = '0;
        b_rstn = 1'b0; b_i_req = 1'b0; b_i_addr = '0; b_d_req = 1'b0; b_d_we = 1'b0; b_d_be = '0;
        b_d_addr = '0; b_d_wdata = '0; b_pl_we = 1'b0; b_pl_idx = '0; b_pl_data = '0;
        test_reset();
        test_single_fetch();
        test_data_write();
        test_withdrawn();
        test_burst_fairness();
        test_lat3_read();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
